// File: rtl/game_step_scheduler.sv
// Game step scheduler.
// Runs one game step per accepted game tick as four phases in a fixed order:
// Pac-Man move, ghost move (prescaled by GHOST_DIV), collision check, commit.
// Each phase unit is driven through a level req / done handshake.
//
// Ports:
//   Clk, Reset_n     system clock, asynchronous active-low reset
//   game_tick        single-cycle pulse, one per game step
//   run              1 = running, 0 = paused (a step in flight still completes)
//   *_done           phase unit finished (only sampled while its req is high)
//   *_req            phase request, high for the whole phase
//   busy             a step is in progress
//   step_count       completed steps, wraps
//   overrun          ticks dropped while busy, saturating at 255
//   timeout_err      sticky, some phase hit the TIMEOUT limit
module game_step_scheduler #(
    parameter int GHOST_DIV = 2,
    parameter int TIMEOUT   = 4096,
    parameter int CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             game_tick,
    input  logic             run,
    input  logic             pac_done,
    input  logic             ghost_done,
    input  logic             coll_done,
    input  logic             commit_done,
    output logic             pac_req,
    output logic             ghost_req,
    output logic             coll_req,
    output logic             commit_req,
    output logic             busy,
    output logic [CNT_W-1:0] step_count,
    output logic [7:0]       overrun,
    output logic             timeout_err
);

    localparam int GD_W = (GHOST_DIV > 1) ? $clog2(GHOST_DIV) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, PAC, GHOST, COLL, COMMIT} state_t;

    state_t          state, state_nxt;
    logic            pending;
    logic [GD_W-1:0] ghost_div;
    logic [TO_W-1:0] ph_cnt;
    logic            cur_done;
    logic            at_limit;
    logic            phase_end;
    logic            timed_out;
    logic            start;
    logic            ghost_due;

    assign busy      = (state != IDLE);
    // ph_cnt counts cycles spent in the current phase, 0 on the first req cycle,
    // so hitting TIMEOUT-1 means req has been high for exactly TIMEOUT cycles.
    assign at_limit  = (ph_cnt == TO_W'(TIMEOUT - 1));
    assign phase_end = busy && (cur_done || at_limit);
    assign timed_out = busy && at_limit && !cur_done;
    assign start     = (state == IDLE) && run && (game_tick || pending);
    assign ghost_due = (ghost_div == GD_W'(GHOST_DIV - 1));

    always_comb begin
        state_nxt  = state;
        cur_done   = 1'b0;
        pac_req    = 1'b0;
        ghost_req  = 1'b0;
        coll_req   = 1'b0;
        commit_req = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = PAC;
            end
            PAC: begin
                pac_req  = 1'b1;
                cur_done = pac_done;
                if (phase_end) state_nxt = ghost_due ? GHOST : COLL;
            end
            GHOST: begin
                ghost_req = 1'b1;
                cur_done  = ghost_done;
                if (phase_end) state_nxt = COLL;
            end
            COLL: begin
                coll_req = 1'b1;
                cur_done = coll_done;
                if (phase_end) state_nxt = COMMIT;
            end
            COMMIT: begin
                commit_req = 1'b1;
                cur_done   = commit_done;
                if (phase_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ph_cnt      <= '0;
            pending     <= 1'b0;
            overrun     <= '0;
            ghost_div   <= '0;
            step_count  <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (!busy || phase_end) ph_cnt <= '0;
            else                    ph_cnt <= ph_cnt + TO_W'(1);

            // A tick arriving with the step start is consumed by that start.
            // While busy, one tick is queued; further ticks are counted as lost.
            if (start) begin
                pending <= 1'b0;
            end else if (busy && game_tick) begin
                if (!pending)              pending <= 1'b1;
                else if (overrun != 8'hFF) overrun <= overrun + 8'd1;
            end

            if (state == COMMIT && phase_end) begin
                step_count <= step_count + CNT_W'(1);
                ghost_div  <= ghost_due ? '0 : ghost_div + GD_W'(1);
            end

            if (timed_out) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_game_step_scheduler.sv
// Bench for game_step_scheduler: directed scenarios plus a randomized run
// checked against a step-level timeline model.
module tb_game_step_scheduler;

    localparam int GD   = 2;
    localparam int TO   = 16;
    localparam int CW   = 16;
    localparam int NEVER = 999;

    logic          Clk;
    logic          Reset_n;
    logic          game_tick;
    logic          run;
    logic          pac_done, ghost_done, coll_done, commit_done;
    logic          pac_req, ghost_req, coll_req, commit_req;
    logic          busy;
    logic [CW-1:0] step_count;
    logic [7:0]    overrun;
    logic          timeout_err;

    game_step_scheduler #(.GHOST_DIV(GD), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .game_tick(game_tick), .run(run),
        .pac_done(pac_done), .ghost_done(ghost_done), .coll_done(coll_done),
        .commit_done(commit_done), .pac_req(pac_req), .ghost_req(ghost_req),
        .coll_req(coll_req), .commit_req(commit_req), .busy(busy),
        .step_count(step_count), .overrun(overrun), .timeout_err(timeout_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Per-step done delays: phase p of step s finishes dly[s][p] cycles after
    // its req rises (phase length dly+1). Phases: 0 pac, 1 ghost, 2 coll, 3 commit.
    int dly [64][4];
    // Phase-entry log: cycle*8 + phase.
    int ev_q [$];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // Phase unit responder and phase-entry monitor.
    initial begin
        int ph, prev_ph, k, dd, rsp_step;
        prev_ph = 4; k = 0; rsp_step = -1;
        pac_done = 0; ghost_done = 0; coll_done = 0; commit_done = 0;
        forever begin
            @(posedge Clk); #1;
            if (!Reset_n) rsp_step = -1;
            ph = pac_req ? 0 : ghost_req ? 1 : coll_req ? 2 : commit_req ? 3 : 4;
            if (ph != prev_ph) begin
                k = 0;
                if (ph == 0) rsp_step++;
                if (ph < 4) ev_q.push_back(cyc * 8 + ph);
            end else begin
                k++;
            end
            dd = (ph < 4 && rsp_step >= 0) ? dly[rsp_step % 64][ph] : NEVER;
            pac_done    = (ph == 0) && (k == dd);
            ghost_done  = (ph == 1) && (k == dd);
            coll_done   = (ph == 2) && (k == dd);
            commit_done = (ph == 3) && (k == dd);
            prev_ph = ph;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic nxt();
        @(posedge Clk); #1;
    endtask

    task automatic pulse_tick(output int t);
        game_tick = 1'b1;
        t = cyc;
        nxt();
        game_tick = 1'b0;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        game_tick = 1'b0;
        run = 1'b1;
        repeat (3) nxt();
        Reset_n = 1'b1;
        nxt();
    endtask

    task automatic clear_dly(input int v);
        for (int s = 0; s < 64; s++)
            for (int p = 0; p < 4; p++) dly[s][p] = v;
    endtask

    function automatic int ev_at(input int i);
        if (i >= 0 && i < ev_q.size()) return ev_q[i];
        return -1;
    endfunction

    function automatic bit ghost_of(input int i);
        return (i % GD) == GD - 1;
    endfunction

    function automatic int step_len(input int i);
        int s;
        s = i % 64;
        return (dly[s][0] + 1) + (ghost_of(i) ? dly[s][1] + 1 : 0)
             + (dly[s][2] + 1) + (dly[s][3] + 1);
    endfunction

    task automatic test_reset();
        Reset_n = 1'b1; game_tick = 1'b0; run = 1'b1;
        #2 Reset_n = 1'b0;
        #1;
        total++;
        if ({pac_req, ghost_req, coll_req, commit_req, busy, timeout_err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {pac_req, ghost_req, coll_req, commit_req, busy, timeout_err});
        end
        total++;
        if (step_count !== '0) begin
            bad++; $display("FAIL reset_step_count got=%0d exp=0", step_count);
        end
        total++;
        if (overrun !== 8'd0) begin
            bad++; $display("FAIL reset_overrun got=%0d exp=0", overrun);
        end
        clear_dly(0);
        do_reset();
    endtask

    task automatic test_basic();
        int t, base;
        clear_dly(2);
        do_reset();
        base = ev_q.size();
        pulse_tick(t);
        repeat (8) nxt();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_commit got=%b exp=1", busy); end
        nxt();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_fall got=%b exp=0", busy); end
        total++;
        if (step_count !== 16'd1) begin bad++; $display("FAIL basic_count1 got=%0d exp=1", step_count); end
        total++;
        if (ev_q.size() - base !== 3) begin
            bad++; $display("FAIL basic_nphases1 got=%0d exp=3", ev_q.size() - base);
        end
        total++;
        if ({ev_at(base), ev_at(base+1), ev_at(base+2)} !==
            {(t+1)*8 + 0, (t+4)*8 + 2, (t+7)*8 + 3}) begin
            bad++;
            $display("FAIL basic_order1 got=%0d,%0d,%0d exp=%0d,%0d,%0d",
                     ev_at(base), ev_at(base+1), ev_at(base+2),
                     (t+1)*8, (t+4)*8 + 2, (t+7)*8 + 3);
        end
        base = ev_q.size();
        pulse_tick(t);
        repeat (14) nxt();
        total++;
        if ({ev_at(base), ev_at(base+1), ev_at(base+2), ev_at(base+3)} !==
            {(t+1)*8, (t+4)*8 + 1, (t+7)*8 + 2, (t+10)*8 + 3}) begin
            bad++;
            $display("FAIL basic_order2 got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d",
                     ev_at(base), ev_at(base+1), ev_at(base+2), ev_at(base+3),
                     (t+1)*8, (t+4)*8 + 1, (t+7)*8 + 2, (t+10)*8 + 3);
        end
        total++;
        if (step_count !== 16'd2) begin bad++; $display("FAIL basic_count2 got=%0d exp=2", step_count); end
    endtask

    task automatic test_back_to_back();
        int t, n;
        clear_dly(0);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pulse_tick(t);
            n = 0;
            for (int j = 0; j < 9; j++) begin
                if (busy) n++;
                nxt();
            end
            total++;
            if (n !== (ghost_of(i) ? 4 : 3)) begin
                bad++; $display("FAIL b2b_len step=%0d got=%0d exp=%0d", i, n, ghost_of(i) ? 4 : 3);
            end
        end
        total++;
        if (step_count !== 16'd8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", step_count); end
        total++;
        if (overrun !== 8'd0) begin bad++; $display("FAIL b2b_overrun got=%0d exp=0", overrun); end
    endtask

    task automatic test_overrun();
        int t0, t, base;
        clear_dly(0);
        dly[0][0] = 12;
        do_reset();
        base = ev_q.size();
        pulse_tick(t0);
        for (int k = 0; k < 3; k++) begin
            repeat (2) nxt();
            pulse_tick(t);
        end
        total++;
        if (overrun !== 8'd2) begin bad++; $display("FAIL ovr_count got=%0d exp=2", overrun); end
        repeat (20) nxt();
        total++;
        if ({ev_at(base+1), ev_at(base+3), ev_at(base+4)} !==
            {(t0+14)*8 + 2, (t0+17)*8, (t0+18)*8 + 1}) begin
            bad++;
            $display("FAIL ovr_extra_step got=%0d,%0d,%0d exp=%0d,%0d,%0d",
                     ev_at(base+1), ev_at(base+3), ev_at(base+4),
                     (t0+14)*8 + 2, (t0+17)*8, (t0+18)*8 + 1);
        end
        total++;
        if (step_count !== 16'd2) begin bad++; $display("FAIL ovr_steps got=%0d exp=2", step_count); end
        total++;
        if ({overrun, timeout_err} !== {8'd2, 1'b0}) begin
            bad++; $display("FAIL ovr_final got=%0d/%b exp=2/0", overrun, timeout_err);
        end
    endtask

    task automatic test_pause();
        int t, base;
        clear_dly(0);
        dly[1][1] = 3;
        do_reset();
        pulse_tick(t);
        repeat (5) nxt();
        pulse_tick(t);
        repeat (2) nxt();
        total++;
        if (ghost_req !== 1'b1) begin bad++; $display("FAIL pause_in_ghost got=%b exp=1", ghost_req); end
        run = 1'b0;
        repeat (8) nxt();
        total++;
        if ({step_count, busy} !== {16'd2, 1'b0}) begin
            bad++; $display("FAIL pause_completes got=%0d/%b exp=2/0", step_count, busy);
        end
        base = ev_q.size();
        for (int k = 0; k < 5; k++) begin
            pulse_tick(t);
            nxt();
        end
        run = 1'b1;
        repeat (3) nxt();
        total++;
        if (ev_q.size() - base !== 0) begin
            bad++; $display("FAIL pause_no_req got=%0d exp=0", ev_q.size() - base);
        end
        total++;
        if (overrun !== 8'd0) begin bad++; $display("FAIL pause_overrun got=%0d exp=0", overrun); end
        pulse_tick(t);
        repeat (6) nxt();
        total++;
        if (ev_at(base) !== (t+1)*8) begin
            bad++; $display("FAIL pause_resume got=%0d exp=%0d", ev_at(base), (t+1)*8);
        end
        total++;
        if (step_count !== 16'd3) begin bad++; $display("FAIL pause_count got=%0d exp=3", step_count); end
    endtask

    task automatic test_timeout();
        int t, base;
        clear_dly(0);
        dly[0][2] = NEVER;
        do_reset();
        base = ev_q.size();
        pulse_tick(t);
        repeat (25) nxt();
        total++;
        if ({ev_at(base+1), ev_at(base+2)} !== {(t+2)*8 + 2, (t+18)*8 + 3}) begin
            bad++;
            $display("FAIL timeout_window got=%0d,%0d exp=%0d,%0d",
                     ev_at(base+1), ev_at(base+2), (t+2)*8 + 2, (t+18)*8 + 3);
        end
        total++;
        if ({timeout_err, step_count} !== {1'b1, 16'd1}) begin
            bad++; $display("FAIL timeout_flag got=%b/%0d exp=1/1", timeout_err, step_count);
        end
        pulse_tick(t);
        repeat (6) nxt();
        total++;
        if ({timeout_err, step_count} !== {1'b1, 16'd2}) begin
            bad++; $display("FAIL timeout_sticky got=%b/%0d exp=1/2", timeout_err, step_count);
        end
    endtask

    task automatic test_async_reset();
        int t, base;
        clear_dly(0);
        dly[1][1] = 5;
        do_reset();
        pulse_tick(t);
        repeat (5) nxt();
        pulse_tick(t);
        repeat (2) nxt();
        total++;
        if (ghost_req !== 1'b1) begin bad++; $display("FAIL arst_in_ghost got=%b exp=1", ghost_req); end
        #3 Reset_n = 1'b0;
        #1;
        total++;
        if ({pac_req, ghost_req, coll_req, commit_req, busy} !== 5'b0) begin
            bad++; $display("FAIL arst_reqs got=%b exp=00000",
                            {pac_req, ghost_req, coll_req, commit_req, busy});
        end
        total++;
        if ({step_count, overrun} !== {16'd0, 8'd0}) begin
            bad++; $display("FAIL arst_counters got=%0d/%0d exp=0/0", step_count, overrun);
        end
        repeat (2) nxt();
        Reset_n = 1'b1;
        nxt();
        base = ev_q.size();
        pulse_tick(t);
        repeat (6) nxt();
        total++;
        if ({ev_at(base), ev_at(base+1)} !== {(t+1)*8, (t+2)*8 + 2}) begin
            bad++; $display("FAIL arst_ghost_skip got=%0d,%0d exp=%0d,%0d",
                            ev_at(base), ev_at(base+1), (t+1)*8, (t+2)*8 + 2);
        end
        total++;
        if (step_count !== 16'd1) begin bad++; $display("FAIL arst_count got=%0d exp=1", step_count); end
    endtask

    // Timeline model: each step occupies cycles [start, start+len-1] and the
    // scheduler is idle from start+len. A tick while busy queues one step (more
    // are lost); a queued step starts the cycle after idle is reached.
    task automatic test_random();
        int ticks [$];
        int st [$];
        bit gh [$];
        int t, base, idle_from, pend, ovr, ns, p, nev;
        bit absorbed;
        for (int s = 0; s < 64; s++)
            for (int q = 0; q < 4; q++) dly[s][q] = $urandom_range(0, 4);
        do_reset();
        base = ev_q.size();
        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 10)) nxt();
            pulse_tick(t);
            ticks.push_back(t);
        end

        idle_from = 0; pend = 0; ovr = 0; ns = 0;
        foreach (ticks[i]) begin
            t = ticks[i];
            absorbed = 1'b0;
            if (pend != 0 && t >= idle_from) begin
                absorbed = (t == idle_from);
                st.push_back(idle_from + 1);
                gh.push_back(ghost_of(ns));
                idle_from = idle_from + 1 + step_len(ns);
                ns++; pend = 0;
            end
            if (!absorbed) begin
                if (t < idle_from) begin
                    if (pend != 0) ovr = (ovr < 255) ? ovr + 1 : 255;
                    else           pend = 1;
                end else begin
                    st.push_back(t + 1);
                    gh.push_back(ghost_of(ns));
                    idle_from = t + 1 + step_len(ns);
                    ns++;
                end
            end
        end
        if (pend != 0) begin
            st.push_back(idle_from + 1);
            gh.push_back(ghost_of(ns));
            idle_from = idle_from + 1 + step_len(ns);
            ns++;
        end

        if (idle_from + 2 > cyc) repeat (idle_from + 2 - cyc) nxt();

        total++;
        if (step_count !== CW'(ns)) begin bad++; $display("FAIL rand_steps got=%0d exp=%0d", step_count, ns); end
        total++;
        if (overrun !== 8'(ovr)) begin bad++; $display("FAIL rand_overrun got=%0d exp=%0d", overrun, ovr); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rand_idle got=%b exp=0", busy); end
        p = base; nev = 0;
        foreach (st[i]) begin
            total++;
            if (ev_at(p) !== st[i] * 8) begin
                bad++; $display("FAIL rand_start step=%0d got=%0d exp=%0d", i, ev_at(p), st[i] * 8);
            end
            total++;
            if (((ev_at(p + 1) % 8) == 1) !== gh[i]) begin
                bad++; $display("FAIL rand_ghost step=%0d got=%0d exp=%b", i, ev_at(p + 1) % 8, gh[i]);
            end
            p += gh[i] ? 4 : 3;
            nev += gh[i] ? 4 : 3;
        end
        total++;
        if (ev_q.size() - base !== nev) begin
            bad++; $display("FAIL rand_nphases got=%0d exp=%0d", ev_q.size() - base, nev);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_pause();
        test_timeout();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
